// File: rtl/mux16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin mux select scheduler.
package mux16_pkg;
    localparam int N            = 16;
    localparam int SEL_W        = 4;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of req scanning upward from ptr, wrapping N-1 -> 0.
module rr_pick #(
    parameter int N     = mux16_pkg::N,
    parameter int SEL_W = mux16_pkg::SEL_W
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    logic [SEL_W-1:0] cand;

    // Scan from farthest to nearest so the nearest set bit is the last assignment.
    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin owner of the 16:1 mux select: grant hold with done/drop/timeout release,
// zero-gap handover and a registered copy of the selected data bit.
module mux16_rr_sched #(
    parameter int N        = mux16_pkg::N,
    parameter int SEL_W    = mux16_pkg::SEL_W,
    parameter int MAX_HOLD = mux16_pkg::MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    input  logic [N-1:0]     in,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic             y
);
    import mux16_pkg::*;

    localparam logic [7:0]   HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    state_t           state, state_nx;
    logic [SEL_W-1:0] ptr, ptr_nx, sel_nx;
    logic [7:0]       hold_cnt, hold_nx;
    logic [N-1:0]     pick_req;
    logic [SEL_W-1:0] pick_ptr, pick_idx;
    logic             pick_any;
    logic             timeout, rel;

    assign timeout = (hold_cnt == HOLD_MAX);
    assign rel     = (state == GRANT) && (done || !req[sel] || timeout);

    // While granted, the owner is masked out and the scan starts just past it.
    always_comb begin
        pick_req = req;
        pick_ptr = ptr;
        if (state == GRANT) begin
            pick_req = req & ~gnt;
            pick_ptr = sel + SEL_W'(1);
        end
    end

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        hold_nx  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = GRANT;
                    sel_nx   = pick_idx;
                    hold_nx  = 8'd1;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_nx = sel + SEL_W'(1);
                    if (pick_any) begin
                        sel_nx  = pick_idx;
                        hold_nx = 8'd1;
                    end else if (timeout && req[sel]) begin
                        // A sole requester is regranted rather than starved.
                        hold_nx = 8'd1;
                    end else begin
                        state_nx = IDLE;
                        hold_nx  = 8'd0;
                    end
                end else if (!timeout) begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            y         <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            sel       <= sel_nx;
            hold_cnt  <= hold_nx;
            gnt_valid <= (state_nx == GRANT);
            gnt       <= (state_nx == GRANT) ? (ONE_HOT0 << sel_nx) : '0;
            y         <= (state_nx == GRANT) ? in[sel_nx] : 1'b0;
        end
    end
endmodule

// File: tb/tb_mux16_rr_sched.sv
// Scoreboard bench for mux16_rr_sched: a cycle model queues expected outputs per edge.
module tb_mux16_rr_sched;
    localparam int N        = 16;
    localparam int SEL_W    = 4;
    localparam int MAX_HOLD = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             done  = 1'b0;
    logic [N-1:0]     req   = '0;
    logic [N-1:0]     in    = '0;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     gnt;
    logic             gnt_valid;
    logic             y;

    mux16_rr_sched #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .in        (in),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .y         (y)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] gnt;
        logic        v;
        logic        y;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    int   m_ptr, m_sel, m_hold;
    logic m_v, m_y;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_first(input logic [15:0] r, input int start);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_sel = 0; m_hold = 0; m_v = 1'b0; m_y = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step();
        int          w;
        logic        tmo, rl;
        logic [15:0] mk;
        if (!m_v) begin
            w = rr_first(req, m_ptr);
            if (w >= 0) begin m_sel = w; m_v = 1'b1; m_hold = 1; end
        end else begin
            tmo = (m_hold == MAX_HOLD);
            rl  = done || !req[m_sel] || tmo;
            if (rl) begin
                mk = req;
                mk[m_sel] = 1'b0;
                m_ptr = (m_sel + 1) % N;
                w = rr_first(mk, m_ptr);
                if (w >= 0) begin m_sel = w; m_hold = 1; end
                else if (tmo && req[m_sel]) m_hold = 1;
                else begin m_v = 1'b0; m_hold = 0; end
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
        m_y = m_v ? in[m_sel] : 1'b0;
    endtask

    task automatic step();
        exp_t e;
        model_step();
        e.sel = 4'(m_sel);
        e.gnt = m_v ? (16'h1 << m_sel) : 16'h0;
        e.v   = m_v;
        e.y   = m_y;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("gnt_valid", gnt_valid, e.v);
            chk("gnt", gnt, e.gnt);
            chk("y", y, e.y);
            if (e.v) chk("sel", sel, e.sel);
            chk("onehot_inv", gnt, gnt_valid ? (16'h1 << sel) : 16'h0);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_y", y, 0);
        chk("rst_valid", gnt_valid, 0);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int         order[$];
        int         exp_order[5];
        int         last;
        logic       prev12;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por_sel", sel, 0);
        chk("por_gnt", gnt, 0);
        chk("por_valid", gnt_valid, 0);
        chk("por_y", y, 0);
        rst_n = 1'b1;

        // Idle after reset
        req = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_sel", sel, 0);
        end

        // Single request, then drop
        req = 16'h0020; in = 16'h0020;
        step();
        chk("single_sel", sel, 5);
        chk("single_y", y, 1);
        req = '0;
        step();
        chk("drop_valid", gnt_valid, 0);

        // Round-robin rotation with done every second cycle
        do_reset();
        req = 16'h8003;
        last = -1;
        for (int i = 0; i < 12; i++) begin
            done = (i % 2 == 0);
            in   = 16'($urandom());
            step();
            if (gnt_valid && int'(sel) != last) begin
                order.push_back(int'(sel));
                last = int'(sel);
            end
        end
        done = 1'b0;
        exp_order = '{0, 1, 15, 0, 1};
        chk("rot_count_ge5", (order.size() >= 5), 1);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk($sformatf("rot_order%0d", i), order[i], exp_order[i]);

        // Timeout handover between two holders
        req = 16'h0011;
        for (int i = 0; i < 20; i++) step();
        // Sole requester keeps the grant across timeouts
        req = 16'h0001;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("sole_valid", gnt_valid, 1);
            chk("sole_sel", sel, 0);
        end

        // Asynchronous reset mid-grant
        req = 16'h0200;
        for (int i = 0; i < 3; i++) step();
        chk("own9_sel", sel, 9);
        do_reset();
        req = 16'hFFFF;
        step();
        chk("post_rst_sel", sel, 0);

        // Data path: owner 12, in[12] and in[3] toggle in opposite phase
        req = 16'h1000;
        step();
        chk("own12_sel", sel, 12);
        for (int i = 0; i < 8; i++) begin
            in[12] = ~in[12];
            in[3]  = ~in[12];
            prev12 = in[12];
            step();
            chk("dp_y", y, prev12);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            req  = (i % 3 == 0) ? 16'($urandom()) : 16'($urandom() & $urandom() & $urandom());
            done = ($urandom_range(3) == 0);
            in   = 16'($urandom());
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
